// File: rtl/data_io_sync.sv
// data_io_sync: SPI slave that links an MCU to the FPGA. It handles file
// download (ioctl), the menu status word, the core variant, config bytes,
// and readback of config-string and data_in bytes. SPI lines are
// oversampled into clk_sys.
module data_io_sync #(
  parameter int DW    = 8,
  parameter int AW    = 25,
  parameter int STW   = 32,
  parameter int CFG_N = 16,
  parameter int SYNC  = 2
) (
  input  logic                   clk_sys,
  input  logic                   rst,
  input  logic                   SPI_SCK,
  input  logic                   SPI_SS2,
  input  logic                   SPI_DI,
  output logic                   SPI_DO,
  input  logic [7:0]             data_in,
  output logic [9:0]             conf_addr,
  input  logic [7:0]             conf_chr,
  output logic [STW-1:0]         status,
  output logic [6:0]             core_mod,
  output logic [CFG_N-1:0][7:0]  config_buffer_o,
  output logic                   ioctl_download,
  output logic [7:0]             ioctl_index,
  output logic                   ioctl_wr,
  input  logic                   ioctl_wait,
  output logic [AW-1:0]          ioctl_addr,
  output logic [DW-1:0]          ioctl_dout,
  output logic                   ioctl_overrun
);

  localparam int STB = STW / 8;

  logic [SYNC-1:0] sck_sync_r, ss_sync_r, di_sync_r;
  logic            sck_prev_r;
  logic            sck_s, ss_s, di_s, sck_rise_s, sck_fall_s;
  logic [2:0]      bit_cnt_r;
  logic [6:0]      sin_r, sout_r;
  logic            first_r, do_r;
  logic [9:0]      byte_cnt_r;
  logic [7:0]      cmd_r, byte_s, resp_s;
  logic            byte_done_s, cmd_done_s, pay_done_s;
  logic            data_s, complete_s, start_s, end_s, accept_s, busy_s;
  logic            half_r, flush_pend_r;
  logic [7:0]      lo_r;
  logic [AW-1:0]   addr_r, addr_nxt_s;
  logic [DW-1:0]   word_s, flush_s;

  assign sck_s       = sck_sync_r[SYNC-1];
  assign ss_s        = ss_sync_r[SYNC-1];
  assign di_s        = di_sync_r[SYNC-1];
  assign sck_rise_s  = sck_s & ~sck_prev_r;
  assign sck_fall_s  = ~sck_s & sck_prev_r;
  assign byte_s      = {sin_r, di_s};
  assign byte_done_s = sck_rise_s & ~ss_s & (bit_cnt_r == 3'd7);
  assign cmd_done_s  = byte_done_s & first_r;
  assign pay_done_s  = byte_done_s & ~first_r;
  assign conf_addr   = byte_cnt_r;
  assign SPI_DO      = ss_s ? 1'bz : do_r;

  assign accept_s    = ioctl_wr & ~ioctl_wait;
  assign busy_s      = ioctl_wr & ioctl_wait;
  assign data_s      = pay_done_s & (cmd_r == 8'h61) & ioctl_download;
  assign complete_s  = data_s & ((DW == 8) ? 1'b1 : half_r);
  assign start_s     = cmd_done_s & (byte_s == 8'h61) & ~ioctl_download;
  assign end_s       = cmd_done_s & (byte_s == 8'h62) & ioctl_download;
  assign addr_nxt_s  = addr_r + AW'(DW / 8);

  // Word assembly: 16-bit words are little-endian, even byte held in lo_r.
  if (DW == 16) begin : g_w16
    assign word_s  = half_r ? {byte_s, lo_r} : {8'h00, byte_s};
    assign flush_s = {8'h00, lo_r};
  end else begin : g_w8
    assign word_s  = byte_s;
    assign flush_s = lo_r;
  end

  // Oversample the SPI pins into clk_sys and keep the previous SCK for edge detect.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sck_sync_r <= '0;
      ss_sync_r  <= '1;
      di_sync_r  <= '0;
      sck_prev_r <= 1'b0;
    end else begin
      sck_sync_r <= {sck_sync_r[SYNC-2:0], SPI_SCK};
      ss_sync_r  <= {ss_sync_r[SYNC-2:0], SPI_SS2};
      di_sync_r  <= {di_sync_r[SYNC-2:0], SPI_DI};
      sck_prev_r <= sck_s;
    end
  end

  // Select the byte shifted out after the current byte boundary.
  always_comb begin
    resp_s = 8'h00;
    case (cmd_r)
      8'h00: begin
        if (ioctl_overrun) resp_s = 8'h45;
        else               resp_s = 8'h4B;
      end
      8'h10:   resp_s = data_in;
      8'h14:   resp_s = conf_chr;
      default: resp_s = 8'h00;
    endcase
  end

  // SPI framing: shift MOSI on SCK rise, MISO on SCK fall, count bits and bytes.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      bit_cnt_r  <= 3'd0;
      sin_r      <= 7'd0;
      sout_r     <= 7'd0;
      first_r    <= 1'b1;
      byte_cnt_r <= 10'd0;
      cmd_r      <= 8'h00;
      do_r       <= 1'b0;
    end else if (ss_s) begin
      bit_cnt_r  <= 3'd0;
      byte_cnt_r <= 10'd0;
      first_r    <= 1'b1;
      sout_r     <= 7'd0;
      do_r       <= 1'b0;
    end else begin
      if (sck_rise_s) begin
        bit_cnt_r <= bit_cnt_r + 3'd1;
        sin_r     <= {sin_r[5:0], di_s};
        if (bit_cnt_r == 3'd7) begin
          if (first_r) begin
            cmd_r   <= byte_s;
            first_r <= 1'b0;
          end else begin
            byte_cnt_r <= byte_cnt_r + 10'd1;
          end
        end
      end
      if (sck_fall_s) begin
        if (bit_cnt_r == 3'd0) begin
          do_r   <= resp_s[7];
          sout_r <= resp_s[6:0];
        end else begin
          do_r   <= sout_r[6];
          sout_r <= {sout_r[5:0], 1'b0};
        end
      end
    end
  end

  // Payload bytes of status, index and config commands update their registers.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      status          <= '0;
      core_mod        <= 7'd0;
      config_buffer_o <= '0;
      ioctl_index     <= 8'h00;
    end else if (pay_done_s) begin
      case (cmd_r)
        8'h15: begin
          for (int i = 0; i < STB; i++)
            if (byte_cnt_r == 10'(STB - 1 - i)) status[8*i +: 8] <= byte_s;
          if (byte_cnt_r == 10'(STB)) core_mod <= byte_s[6:0];
        end
        8'h55: ioctl_index <= byte_s;
        8'h60: begin
          for (int i = 0; i < CFG_N; i++)
            if (byte_cnt_r == 10'(CFG_N - 1 - i)) config_buffer_o[i] <= byte_s;
        end
        default: ;
      endcase
    end
  end

  // Download engine: start/end, byte packing, write handshake and overrun.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      ioctl_download <= 1'b0;
      ioctl_wr       <= 1'b0;
      ioctl_addr     <= '0;
      ioctl_dout     <= '0;
      ioctl_overrun  <= 1'b0;
      addr_r         <= '0;
      half_r         <= 1'b0;
      lo_r           <= 8'h00;
      flush_pend_r   <= 1'b0;
    end else begin
      if (accept_s) begin
        ioctl_wr <= 1'b0;
        if (flush_pend_r) begin
          ioctl_download <= 1'b0;
          flush_pend_r   <= 1'b0;
        end
      end
      if (start_s) begin
        ioctl_download <= 1'b1;
        addr_r         <= '0;
        half_r         <= 1'b0;
        lo_r           <= 8'h00;
        ioctl_overrun  <= 1'b0;
      end
      if (end_s) begin
        if (half_r) begin
          // A pending odd byte is flushed; download ends once it is taken.
          half_r <= 1'b0;
          addr_r <= addr_nxt_s;
          if (busy_s) begin
            ioctl_overrun  <= 1'b1;
            ioctl_download <= 1'b0;
          end else begin
            ioctl_wr     <= 1'b1;
            ioctl_dout   <= flush_s;
            ioctl_addr   <= addr_r;
            flush_pend_r <= 1'b1;
          end
        end else begin
          ioctl_download <= 1'b0;
        end
      end
      if (complete_s) begin
        half_r <= 1'b0;
        addr_r <= addr_nxt_s;
        if (busy_s) begin
          ioctl_overrun <= 1'b1;
        end else begin
          ioctl_wr   <= 1'b1;
          ioctl_dout <= word_s;
          ioctl_addr <= addr_r;
        end
      end else if (data_s) begin
        lo_r   <= byte_s;
        half_r <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_io_sync.sv
// Bench for data_io_sync: a DW=8 and a DW=16 instance share the SPI bus and
// are checked against a transaction-level model of the protocol.
module tb_data_io_sync;

  logic clk = 1'b0, rst = 1'b1, sck = 1'b0, ss = 1'b1, di = 1'b0, wait_in = 1'b0;
  logic [7:0] data_in = 8'h00;
  wire miso8, miso16;
  pullup pu8 (miso8);
  pullup pu16 (miso16);

  logic [9:0]       ca8, ca16;
  logic [7:0]       cc8, cc16;
  logic [31:0]      st8, st16;
  logic [6:0]       cm8, cm16;
  logic [15:0][7:0] cfg8, cfg16;
  logic             dl8, dl16, wr8, wr16, ov8, ov16;
  logic [7:0]       ix8, ix16, do8;
  logic [24:0]      ad8, ad16;
  logic [15:0]      do16;

  // conf string model: character at index a is a ^ 0x5A
  assign cc8  = ca8[7:0] ^ 8'h5A;
  assign cc16 = ca16[7:0] ^ 8'h5A;

  always #5 clk = ~clk;

  data_io_sync #(.DW(8)) u8 (
    .clk_sys(clk), .rst(rst), .SPI_SCK(sck), .SPI_SS2(ss), .SPI_DI(di), .SPI_DO(miso8),
    .data_in(data_in), .conf_addr(ca8), .conf_chr(cc8), .status(st8), .core_mod(cm8),
    .config_buffer_o(cfg8), .ioctl_download(dl8), .ioctl_index(ix8), .ioctl_wr(wr8),
    .ioctl_wait(wait_in), .ioctl_addr(ad8), .ioctl_dout(do8), .ioctl_overrun(ov8));

  data_io_sync #(.DW(16)) u16 (
    .clk_sys(clk), .rst(rst), .SPI_SCK(sck), .SPI_SS2(ss), .SPI_DI(di), .SPI_DO(miso16),
    .data_in(data_in), .conf_addr(ca16), .conf_chr(cc16), .status(st16), .core_mod(cm16),
    .config_buffer_o(cfg16), .ioctl_download(dl16), .ioctl_index(ix16), .ioctl_wr(wr16),
    .ioctl_wait(wait_in), .ioctl_addr(ad16), .ioctl_dout(do16), .ioctl_overrun(ov16));

  int checks = 0, errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_dl[2], m_half[2], m_ovr[2], m_held[2];
  bit          m_wait;
  int unsigned m_addr[2];
  logic [7:0]  m_lo[2];
  logic [31:0] m_status;
  logic [6:0]  m_core;
  logic [7:0]  m_index;
  logic [7:0]  m_cfg[16];
  logic [40:0] q0[$], q1[$];
  logic [7:0]  tx[16];
  logic [7:0]  rx[2][16], exp_rx[2][16];
  logic [24:0] last_a[2];
  logic [15:0] last_d[2];

  function automatic void model_reset();
    for (int d = 0; d < 2; d++) begin
      m_dl[d] = 0; m_half[d] = 0; m_ovr[d] = 0; m_held[d] = 0; m_addr[d] = 0; m_lo[d] = 8'h00;
    end
    m_status = 32'h0; m_core = 7'h0; m_index = 8'h00;
    for (int i = 0; i < 16; i++) m_cfg[i] = 8'h00;
    q0.delete(); q1.delete();
  endfunction

  // A completed word goes to the sink unless one is still held there.
  function automatic void emit(int d, logic [15:0] w);
    logic [40:0] e;
    e = {25'(m_addr[d]), w};
    if (m_held[d]) m_ovr[d] = 1;
    else begin
      if (d == 0) q0.push_back(e); else q1.push_back(e);
      m_held[d] = m_wait;
    end
    m_addr[d] = (m_addr[d] + ((d == 0) ? 1 : 2)) % (1 << 25);
  endfunction

  function automatic void model_cmd(int d, logic [7:0] c);
    if (c == 8'h61 && !m_dl[d]) begin
      m_dl[d] = 1; m_addr[d] = 0; m_half[d] = 0; m_ovr[d] = 0;
    end else if (c == 8'h62 && m_dl[d]) begin
      if (m_half[d]) begin emit(d, {8'h00, m_lo[d]}); m_half[d] = 0; end
      m_dl[d] = 0;
    end
  endfunction

  // Returns the MISO byte expected during payload byte k and applies its effect.
  function automatic logic [7:0] model_byte(int d, logic [7:0] c, int k, logic [7:0] b);
    logic [7:0] r;
    case (c)
      8'h00:   r = m_ovr[d] ? 8'h45 : 8'h4B;
      8'h10:   r = data_in;
      8'h14:   r = 8'(k) ^ 8'h5A;
      default: r = 8'h00;
    endcase
    if (d == 0) begin
      if (c == 8'h15 && k < 4) m_status[31 - 8*k -: 8] = b;
      if (c == 8'h15 && k == 4) m_core = b[6:0];
      if (c == 8'h55) m_index = b;
      if (c == 8'h60 && k < 16) m_cfg[15 - k] = b;
    end
    if (c == 8'h61 && m_dl[d]) begin
      if (d == 0) emit(0, {8'h00, b});
      else if (!m_half[1]) begin m_lo[1] = b; m_half[1] = 1; end
      else begin emit(1, {b, m_lo[1]}); m_half[1] = 0; end
    end
    return r;
  endfunction

  // ---------------- write-port compare process ----------------
  task automatic cmp_wr(input int d, input logic w, input logic [24:0] a, input logic [15:0] v);
    logic [40:0] e;
    if (w) begin
      if ((d == 0 ? q0.size() : q1.size()) == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_write dut%0d: addr %0h data %0h, none expected", d, a, v);
      end else begin
        e = (d == 0) ? q0[0] : q1[0];
        chk($sformatf("wr_addr dut%0d", d), a, e[40:16]);
        chk($sformatf("wr_data dut%0d", d), v, e[15:0]);
        if (!wait_in) begin
          if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
          last_a[d] = a; last_d[d] = v;
        end
      end
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      cmp_wr(0, wr8, ad8, {8'h00, do8});
      cmp_wr(1, wr16, ad16, do16);
    end
  end

  // ---------------- SPI master ----------------
  task automatic send_byte(input logic [7:0] v, input int k);
    logic [7:0] r0, r1;
    r0 = 8'h00; r1 = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      di = v[i];
      #50;
      r0 = {r0[6:0], miso8};
      r1 = {r1[6:0], miso16};
      sck = 1'b1;
      #50;
      sck = 1'b0;
    end
    if (k >= 0) begin rx[0][k] = r0; rx[1][k] = r1; end
  endtask

  task automatic xfer(input logic [7:0] c, input int n);
    @(negedge clk);
    for (int d = 0; d < 2; d++) model_cmd(d, c);
    ss = 1'b0;
    #50;
    send_byte(c, -1);
    for (int k = 0; k < n; k++) begin
      for (int d = 0; d < 2; d++) exp_rx[d][k] = model_byte(d, c, k, tx[k]);
      send_byte(tx[k], k);
    end
    #50;
    ss = 1'b1;
    #200;
    for (int k = 0; k < n; k++)
      for (int d = 0; d < 2; d++)
        chk($sformatf("miso cmd%0h dut%0d byte%0d", c, d, k), rx[d][k], exp_rx[d][k]);
    chk("miso_release dut0", miso8, 1'b1);
    chk("miso_release dut1", miso16, 1'b1);
  endtask

  task automatic chk_state();
    chk("download dut0", dl8, m_dl[0]);
    chk("download dut1", dl16, m_dl[1]);
    chk("overrun dut0", ov8, m_ovr[0]);
    chk("overrun dut1", ov16, m_ovr[1]);
    chk("status dut0", st8, m_status);
    chk("status dut1", st16, m_status);
    chk("core_mod dut0", cm8, m_core);
    chk("core_mod dut1", cm16, m_core);
    chk("index dut0", ix8, m_index);
    chk("index dut1", ix16, m_index);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("cfg%0d dut0", i), cfg8[i], m_cfg[i]);
      chk($sformatf("cfg%0d dut1", i), cfg16[i], m_cfg[i]);
    end
  endtask

  initial begin
    model_reset();
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst wr", {wr8, wr16}, 2'b00);
    chk("rst addr", {ad8, ad16}, 50'h0);
    chk("rst dout", {do8, do16}, 24'h0);
    chk("rst conf_addr", {ca8, ca16}, 20'h0);
    chk("rst cfg", {cfg8, cfg16}, 64'h0);
    chk("rst miso", {miso8, miso16}, 2'b11);
    chk_state();

    // ACK readback
    xfer(8'h00, 2);
    chk("ack literal", {rx[0][0], rx[0][1], rx[1][0]}, 24'h4B4B4B);

    // DW=8 two bytes, then end
    tx[0] = 8'hAA; tx[1] = 8'h55;
    xfer(8'h61, 2);
    chk_state();
    chk("dl literal", {dl8, dl16}, 2'b11);
    chk("dw8 last literal", {last_a[0], last_d[0]}, {25'd1, 16'h0055});
    xfer(8'h62, 0);
    chk_state();

    // DW=16 odd byte count with flush on end
    tx[0] = 8'h11; tx[1] = 8'h22; tx[2] = 8'h33;
    xfer(8'h61, 3);
    xfer(8'h62, 0);
    chk_state();
    chk("dw16 flush literal", {last_a[1], last_d[1]}, {25'd2, 16'h0033});

    // download spanning two transactions
    tx[0] = 8'h01; tx[1] = 8'h02;
    xfer(8'h61, 2);
    tx[0] = 8'h03; tx[1] = 8'h04;
    xfer(8'h61, 2);
    chk("span literal", {last_a[0], last_d[0]}, {25'd3, 16'h0004});
    xfer(8'h62, 0);
    chk_state();

    // backpressure and overrun
    @(negedge clk);
    wait_in = 1'b1; m_wait = 1;
    tx[0] = 8'hA0; tx[1] = 8'hA1; tx[2] = 8'hA2; tx[3] = 8'hA3;
    xfer(8'h61, 4);
    chk_state();
    chk("held literal", {wr8, do8, wr16, do16, ov8, ov16}, {1'b1, 8'hA0, 1'b1, 16'hA1A0, 2'b11});
    xfer(8'h00, 1);
    chk("nak literal", {rx[0][0], rx[1][0]}, 16'h4545);
    @(negedge clk);
    wait_in = 1'b0; m_wait = 0; m_held[0] = 0; m_held[1] = 0;
    repeat (5) @(negedge clk);
    chk("released wr", {wr8, wr16}, 2'b00);
    xfer(8'h62, 0);
    tx[0] = 8'h77;
    xfer(8'h61, 1);
    chk_state();
    chk("ovr cleared literal", {ov8, ov16}, 2'b00);
    xfer(8'h62, 0);
    xfer(8'h00, 1);
    chk_state();

    // status, core_mod, config, index
    tx[0] = 8'h12; tx[1] = 8'h34; tx[2] = 8'h56; tx[3] = 8'h78; tx[4] = 8'h85;
    xfer(8'h15, 5);
    chk("status literal", {st8, cm8}, {32'h12345678, 7'h05});
    tx[0] = 8'hA1; tx[1] = 8'hB2;
    xfer(8'h60, 2);
    chk("cfg literal", {cfg8[15], cfg8[14], cfg8[13]}, 24'hA1B200);
    tx[0] = 8'h01; tx[1] = 8'h02; tx[2] = 8'h07;
    xfer(8'h55, 3);
    chk_state();

    // readback commands
    data_in = 8'hC3;
    xfer(8'h10, 2);
    tx[0] = 8'h00; tx[1] = 8'h00; tx[2] = 8'h00;
    xfer(8'h14, 3);
    chk("conf literal", {rx[0][0], rx[0][1], rx[0][2]}, 24'h5A5B58);
    xfer(8'h33, 1);

    // reset in the middle of a download aborts without flush
    tx[0] = 8'h9C;
    xfer(8'h61, 1);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk_state();
    chk("no flush after rst", wr16, 1'b0);

    chk("pending writes dut0", q0.size(), 0);
    chk("pending writes dut1", q1.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
